color_space_engine: RTL and testbench
=====================================

COLOR_SPACE_ENGINE -- requirements
Module: color_space_engine

Interface
REQ-001 SHALL have parameter PIX_W, default 8, meaning component width in bits; legal range 8..10.
REQ-002 SHALL have parameter COEF_W, default 16, meaning signed coefficient width.
REQ-003 SHALL have parameter FRAC_W, default 14, meaning coefficient fraction bits.
REQ-004 SHALL have parameter FIFO_DEPTH, default 8, meaning result FIFO entries; power of two, at least 2.
REQ-005 SHALL have port CLK_I, input, 1 bit, the single clock; all flops on rising edge.
REQ-006 SHALL have port RST_I, input, 1 bit, asynchronous active-low reset.
REQ-007 SHALL have Wishbone slave ports: CYC_I in 1, STB_I in 1, WE_I in 1, ADR_I in 32, SEL_I in 4, DAT_I in 32, DAT_O out 32, ACK_O out 1.
REQ-008 SHALL use byte offsets ADR_I[5:0]:
- 0x00 PIX (W): {R,G,B} in DAT_I[3*PIX_W-1:0], R most significant.
- 0x04 RESULT (R, pops FIFO): {Y,Cb,Cr} in [3*PIX_W-1:0].
- 0x08 STATUS (R): [7:0] fifo count, [8] empty, [9] full, [10] busy, [11] sticky underflow.
- 0x0C CTRL (R/W): [0] bypass; [1] flush, write-only, self-clearing; [2] write 1 to clear underflow.
- 0x10..0x30 COEF0..COEF8 (R/W), order Y_R Y_G Y_B Cb_R Cb_G Cb_B Cr_R Cr_G Cr_B, sign-extended on read.

Function
REQ-009 SHALL pulse ACK_O high for exactly one cycle per accepted access, the cycle after acceptance; it SHALL deassert even if STB_I stays high.
REQ-010 SHALL accept writes to PIX and COEFn only when the engine is IDLE; otherwise ACK_O is withheld (wait states) until IDLE.
REQ-011 SHALL ignore PIX writes with SEL_I != 4'b1111, acknowledged, no engine start.
REQ-012 SHALL acknowledge unmapped addresses, return 0 on read, ignore writes.
REQ-013 SHALL drive DAT_O with read data only in the ACK cycle and 0 otherwise.
REQ-014 SHALL implement engine FSM IDLE -> MAC -> SAT -> PUSH -> IDLE; the accepted PIX write moves IDLE to MAC.
REQ-015 SHALL use one signed multiplier in MAC for 9 cycles (index 0..8), accumulating one coefficient x zero-extended component per cycle into three accumulators.
REQ-016 SHALL preload the accumulators with offset<<FRAC_W plus rounding constant 1<<(FRAC_W-1):
- Y offset = 0.
- Cb and Cr offset = 2^(PIX_W-1).
REQ-017 SHALL make accumulators wide enough never to overflow: PIX_W+COEF_W+3 bits.
REQ-018 SHALL in SAT arithmetic-shift right by FRAC_W and clamp to [0, 2^PIX_W-1].
REQ-019 SHALL in PUSH write {Y,Cb,Cr} to the FIFO; if the FIFO is full, PUSH holds (busy stays 1) until space exists; no result is ever dropped.
REQ-020 SHALL have fixed latency with a non-full FIFO: PIX ACK at cycle T -> result counted in STATUS at cycle T+12.
REQ-021 SHALL in bypass mode (CTRL[0]=1) skip MAC and SAT, pushing {R,G,B} unchanged; latency T+2.
REQ-022 SHALL on RESULT read of a non-empty FIFO return the head and pop; on an empty FIFO return 0, leave count unchanged and set underflow.
REQ-023 SHALL leave the count unchanged when push and pop occur in the same cycle; the pointers wrap modulo FIFO_DEPTH.
REQ-024 SHALL on flush empty the FIFO, abort the engine to IDLE within 1 cycle and discard any in-flight result; coefficients are retained.

Reset
REQ-025 SHALL on RST_I low, asynchronously:
- ACK_O=0, DAT_O=0.
- FSM=IDLE.
- FIFO empty, count 0.
- bypass=0, underflow=0.
REQ-026 SHALL reset coefficients to BT.601 in Q2.14: 4899, 9617, 1868, -2764, -5428, 8192, 8192, -6860, -1332.
REQ-027 SHALL make reset during MAC or PUSH discard the pixel; no partial result appears after release.

Verification
REQ-028 Write PIX 0x00FFFFFF -> RESULT reads 0x00FF8080.
REQ-029 Write PIX 0x00FF0000 -> RESULT reads 0x004C55FF (Y=76, Cb=85, Cr saturated to 255).
REQ-030 9 PIX writes with no reads, FIFO_DEPTH=8 -> 9th write ACKs, STATUS full=1 and busy=1; one RESULT read -> busy drops, count stays 8.
REQ-031 RESULT read after reset -> DAT_O=0, STATUS[11]=1; CTRL write 0x4 -> STATUS[11]=0.
REQ-032 Set CTRL=0x1, write PIX 0x00123456 -> RESULT 0x00123456 within 2 cycles of ACK.
REQ-033 COEF0 write issued 3 cycles after a PIX ACK -> ACK_O withheld until IDLE; the next pixel uses the new COEF0.

Source files
------------

// File: rtl/color_space_engine_if.sv
// Wishbone classic slave bus bundle for color_space_engine.
//   CYC_I/STB_I/WE_I : cycle, strobe, write enable (master -> slave)
//   ADR_I/SEL_I      : byte address, byte selects
//   DAT_I/DAT_O      : write data in, read data out
//   ACK_O            : single-cycle acknowledge (slave -> master)
interface color_space_engine_if;
  logic        CYC_I;
  logic        STB_I;
  logic        WE_I;
  logic [31:0] ADR_I;
  logic [3:0]  SEL_I;
  logic [31:0] DAT_I;
  logic [31:0] DAT_O;
  logic        ACK_O;

  modport slave  (input  CYC_I, STB_I, WE_I, ADR_I, SEL_I, DAT_I,
                  output DAT_O, ACK_O);
  modport master (output CYC_I, STB_I, WE_I, ADR_I, SEL_I, DAT_I,
                  input  DAT_O, ACK_O);
endinterface

// File: rtl/color_space_engine.sv
// RGB -> YCbCr converter behind a Wishbone slave. A PIX write starts a
// sequential 9-step MAC (one signed multiplier), results are rounded,
// clamped and queued in a result FIFO popped by RESULT reads.
// Ports:
//   CLK_I : clock, rising edge
//   RST_I : asynchronous reset, active low
//   wb    : Wishbone slave (see color_space_engine_if)
// Register map (ADR_I[5:2] word index):
//   0 PIX(W) 1 RESULT(R,pop) 2 STATUS(R) 3 CTRL(R/W) 4..12 COEF0..8(R/W)
module color_space_engine #(
  parameter int PIX_W      = 8,
  parameter int COEF_W     = 16,
  parameter int FRAC_W     = 14,
  parameter int FIFO_DEPTH = 8
)(
  input  logic                 CLK_I,
  input  logic                 RST_I,
  color_space_engine_if.slave  wb
);
  localparam int AW    = PIX_W + COEF_W + 3;  // accumulator width
  localparam int PW    = COEF_W + PIX_W + 1;  // product width
  localparam int RW    = 3 * PIX_W;           // packed pixel/result width
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic signed [AW-1:0] RND  = AW'(1) << (FRAC_W-1);
  localparam logic signed [AW-1:0] COFF = (AW'(1) << (PIX_W-1+FRAC_W)) + RND;
  localparam logic signed [AW-1:0] MAXV = (AW'(1) << PIX_W) - AW'(1);
  localparam int DEF_COEF [9] = '{4899, 9617, 1868, -2764, -5428, 8192,
                                  8192, -6860, -1332};

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_SAT, S_PUSH} state_t;
  state_t state_q, state_d;

  // ---------------- bus decode ----------------
  logic                     ack_q;
  logic [31:0]              dat_q, rdata;
  logic [3:0]               word, coef_sel;
  logic                     req, is_pix, is_coef, gated, accept, wr, rd;
  logic                     flush, start, pop, push, under_set;

  assign word     = wb.ADR_I[5:2];
  assign coef_sel = word - 4'd4;
  assign is_pix   = (word == 4'd0);
  assign is_coef  = (word >= 4'd4) && (word <= 4'd12);
  // ack_q blocks a second acceptance while STB_I is still high in the ACK cycle
  assign req      = wb.CYC_I & wb.STB_I & ~ack_q;
  // PIX/COEF writes stall (no ACK) until the engine is idle
  assign gated    = wb.WE_I & (is_pix | is_coef);
  assign accept   = req & (~gated | (state_q == S_IDLE));
  assign wr       = accept & wb.WE_I;
  assign rd       = accept & ~wb.WE_I;
  assign flush    = wr & (word == 4'd3) & wb.DAT_I[1];
  assign start    = wr & is_pix & (wb.SEL_I == 4'b1111);

  // ---------------- registers ----------------
  logic                     bypass_q, under_q;
  logic signed [COEF_W-1:0] coef_q [9];
  logic [RW-1:0]            pix_q, res_q;
  logic [3:0]               idx_q;
  logic signed [AW-1:0]     acc_y_q, acc_cb_q, acc_cr_q;

  logic [RW-1:0]            mem [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]         cnt_q;
  logic                     full, empty, busy;

  assign full      = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign empty     = (cnt_q == '0);
  assign busy      = (state_q != S_IDLE);
  assign pop       = rd & (word == 4'd1) & ~empty;
  assign under_set = rd & (word == 4'd1) & empty;
  assign push      = (state_q == S_PUSH) & ~full & ~flush;

  // ---------------- engine FSM ----------------
  always_ff @(posedge CLK_I or negedge RST_I)
    if (!RST_I) state_q <= S_IDLE;
    else        state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = bypass_q ? S_PUSH : S_MAC;
      S_MAC:  if (idx_q == 4'd8) state_d = S_SAT;
      S_SAT:  state_d = S_PUSH;
      S_PUSH: if (!full) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  // ---------------- MAC datapath ----------------
  logic [PIX_W-1:0]         comp;
  logic signed [COEF_W-1:0] coef_cur;
  logic signed [PW-1:0]     prod;
  logic signed [AW-1:0]     prod_x;

  always_comb begin
    comp = pix_q[PIX_W-1:0];
    case (idx_q)
      4'd0, 4'd3, 4'd6: comp = pix_q[RW-1:2*PIX_W];
      4'd1, 4'd4, 4'd7: comp = pix_q[2*PIX_W-1:PIX_W];
      default: ;
    endcase
  end

  assign coef_cur = coef_q[idx_q];
  // component is zero-extended so it multiplies as a non-negative value
  assign prod     = coef_cur * $signed({1'b0, comp});
  assign prod_x   = {{(AW-PW){prod[PW-1]}}, prod};

  function automatic logic [PIX_W-1:0] sat(input logic signed [AW-1:0] a);
    logic signed [AW-1:0] s;
    s = a >>> FRAC_W;
    if (s < 0)         sat = '0;
    else if (s > MAXV) sat = '1;
    else               sat = s[PIX_W-1:0];
  endfunction

  always_ff @(posedge CLK_I or negedge RST_I)
    if (!RST_I) begin
      pix_q    <= '0;
      res_q    <= '0;
      idx_q    <= '0;
      acc_y_q  <= '0;
      acc_cb_q <= '0;
      acc_cr_q <= '0;
    end else begin
      if (start) begin
        pix_q    <= wb.DAT_I[RW-1:0];
        res_q    <= wb.DAT_I[RW-1:0];  // bypass pushes the pixel as-is
        idx_q    <= '0;
        acc_y_q  <= RND;
        acc_cb_q <= COFF;
        acc_cr_q <= COFF;
      end else if (state_q == S_MAC) begin
        if (idx_q != 4'd8) idx_q <= idx_q + 4'd1;
        if (idx_q < 4'd3)      acc_y_q  <= acc_y_q  + prod_x;
        else if (idx_q < 4'd6) acc_cb_q <= acc_cb_q + prod_x;
        else                   acc_cr_q <= acc_cr_q + prod_x;
      end else if (state_q == S_SAT) begin
        res_q <= {sat(acc_y_q), sat(acc_cb_q), sat(acc_cr_q)};
      end
    end

  // ---------------- result FIFO ----------------
  always_ff @(posedge CLK_I)
    if (push) mem[wr_ptr_q] <= res_q;

  always_ff @(posedge CLK_I or negedge RST_I)
    if (!RST_I) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (pop && !push) cnt_q <= cnt_q - 1'b1;
    end

  // ---------------- control / coefficient registers ----------------
  always_ff @(posedge CLK_I or negedge RST_I)
    if (!RST_I) begin
      bypass_q <= 1'b0;
      under_q  <= 1'b0;
      for (int i = 0; i < 9; i++) coef_q[i] <= COEF_W'(DEF_COEF[i]);
    end else begin
      if (wr && word == 4'd3) begin
        bypass_q <= wb.DAT_I[0];
        if (wb.DAT_I[2]) under_q <= 1'b0;
      end
      if (under_set) under_q <= 1'b1;
      for (int i = 0; i < 9; i++)
        if (wr && is_coef && coef_sel == 4'(i)) coef_q[i] <= wb.DAT_I[COEF_W-1:0];
    end

  // ---------------- read mux and bus response ----------------
  logic signed [COEF_W-1:0] coef_rd;
  assign coef_rd = coef_q[coef_sel];

  always_comb begin
    rdata = '0;
    case (word)
      4'd1: if (!empty) rdata = {{(32-RW){1'b0}}, mem[rd_ptr_q]};
      4'd2: rdata = {20'b0, under_q, busy, full, empty, 8'(cnt_q)};
      4'd3: rdata = {31'b0, bypass_q};
      default: if (is_coef) rdata = {{(32-COEF_W){coef_rd[COEF_W-1]}}, coef_rd};
    endcase
  end

  always_ff @(posedge CLK_I or negedge RST_I)
    if (!RST_I) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= accept;
      dat_q <= rd ? rdata : 32'b0;  // data only present in the ACK cycle
    end

  assign wb.ACK_O = ack_q;
  assign wb.DAT_O = dat_q;

  logic unused_bits;
  assign unused_bits = ^{wb.ADR_I[31:6], wb.ADR_I[1:0], wb.DAT_I};
endmodule

// File: tb/tb_color_space_engine.sv
module tb_color_space_engine;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;

  color_space_engine_if bus();
  color_space_engine #(.PIX_W(8), .COEF_W(16), .FRAC_W(14), .FIFO_DEPTH(8))
    dut (.CLK_I(clk), .RST_I(rst_n), .wb(bus));

  int total = 0, bad = 0;
  int cyc = 0, ack_cyc = 0;
  always @(posedge clk) cyc++;

  localparam logic [31:0] A_PIX = 32'h00, A_RES = 32'h04, A_STAT = 32'h08,
                          A_CTRL = 32'h0C, A_COEF = 32'h10;

  int          coef_m [9];
  logic [31:0] exp_q [$];
  bit          under_m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, output logic [31:0] rdat);
    int n = 0;
    bus.CYC_I = 1; bus.STB_I = 1; bus.WE_I = we;
    bus.ADR_I = adr; bus.DAT_I = dat; bus.SEL_I = sel;
    @(negedge clk);
    while (!bus.ACK_O && n < 200) begin n++; @(negedge clk); end
    if (!bus.ACK_O) chk("wb_timeout", 32'd0, 32'd1);
    rdat = bus.DAT_O;
    ack_cyc = cyc;
    @(posedge clk); #1;
    bus.CYC_I = 0; bus.STB_I = 0; bus.WE_I = 0;
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] dat);
    logic [31:0] d;
    xfer(1'b1, adr, dat, 4'hF, d);
  endtask

  task automatic rd(input logic [31:0] adr, output logic [31:0] d);
    xfer(1'b0, adr, 32'h0, 4'hF, d);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] adr, input logic [31:0] exp);
    logic [31:0] d;
    rd(adr, d);
    chk(tag, d, exp);
  endtask

  // Reference conversion straight from the arithmetic definition.
  function automatic logic [31:0] ref_csc(input logic [31:0] rgb, input bit byp);
    int c [3];
    int o [3];
    longint s;
    if (byp) return {8'h0, rgb[23:0]};
    c[0] = rgb[23:16]; c[1] = rgb[15:8]; c[2] = rgb[7:0];
    for (int k = 0; k < 3; k++) begin
      s = (k == 0) ? 0 : 128 * 16384;
      s = s + 8192;
      for (int j = 0; j < 3; j++) s = s + longint'(coef_m[k*3+j]) * c[j];
      s = s >>> 14;
      o[k] = (s < 0) ? 0 : (s > 255) ? 255 : int'(s);
    end
    return {8'h0, o[0][7:0], o[1][7:0], o[2][7:0]};
  endfunction

  function automatic logic [31:0] stat_m(input bit busy);
    int n = exp_q.size();
    return {20'h0, under_m, busy, n >= 8, n == 0, 8'(n > 8 ? 8 : n)};
  endfunction

  task automatic pop_chk(input string tag);
    logic [31:0] d, e;
    rd(A_RES, d);
    if (exp_q.size() == 0) begin e = 0; under_m = 1; end
    else e = exp_q.pop_front();
    chk(tag, d, e);
  endtask

  initial begin
    logic [31:0] d, p;
    int t0;
    bit byp;
    bus.CYC_I = 0; bus.STB_I = 0; bus.WE_I = 0;
    bus.ADR_I = 0; bus.DAT_I = 0; bus.SEL_I = 0;
    foreach (coef_m[i]) coef_m[i] = 0;
    coef_m = '{4899, 9617, 1868, -2764, -5428, 8192, 8192, -6860, -1332};
    under_m = 0;

    // reset state
    idle(3);
    chk("rst_ack", {31'b0, bus.ACK_O}, 32'd0);
    chk("rst_dat", bus.DAT_O, 32'd0);
    rst_n = 1;
    idle(2);
    rd_chk("rst_stat", A_STAT, 32'h100);
    rd_chk("rst_coef0", A_COEF, 32'd4899);
    rd_chk("rst_coef3", A_COEF + 12, 32'hFFFFF534);
    rd_chk("rst_ctrl", A_CTRL, 32'd0);
    @(negedge clk);
    chk("dato_idle", bus.DAT_O, 32'd0);
    idle(1);

    // white, with busy/empty sampled just before the push lands
    wr(A_PIX, 32'h00FFFFFF);
    idle(9);
    rd_chk("lat_busy", A_STAT, 32'h500);
    rd_chk("white", A_RES, 32'h00FF8080);

    // red, checking the count becomes visible exactly at T+12
    wr(A_PIX, 32'h00FF0000);
    idle(10);
    rd_chk("lat_cnt", A_STAT, 32'h001);
    rd_chk("red", A_RES, 32'h004C55FF);

    // underflow
    rd_chk("under_dat", A_RES, 32'h0);
    rd_chk("under_stat", A_STAT, 32'h900);
    wr(A_CTRL, 32'h4);
    rd_chk("under_clr", A_STAT, 32'h100);

    // bypass
    wr(A_CTRL, 32'h1);
    rd_chk("ctrl_rd", A_CTRL, 32'h1);
    wr(A_PIX, 32'h00123456);
    rd_chk("bypass", A_RES, 32'h00123456);
    wr(A_CTRL, 32'h0);

    // partial SEL: acknowledged, no engine start
    xfer(1'b1, A_PIX, 32'h00FFFFFF, 4'b0111, d);
    idle(14);
    rd_chk("sel_ign", A_STAT, 32'h100);

    // unmapped
    wr(32'h34, 32'hDEADBEEF);
    rd_chk("unmap34", 32'h34, 32'h0);
    rd_chk("unmap3c", 32'h3C, 32'h0);

    // coefficient sign extension
    wr(A_COEF + 20, 32'h12348000);
    rd_chk("coef_sx", A_COEF + 20, 32'hFFFF8000);
    wr(A_COEF + 20, 32'd8192);

    // nine back-to-back pixels into an 8-entry FIFO
    for (int i = 0; i < 9; i++) begin
      p = {8'h0, 24'($urandom)};
      wr(A_PIX, p);
      exp_q.push_back(ref_csc(p, 0));
    end
    idle(15);
    rd_chk("full_stat", A_STAT, 32'h608);
    pop_chk("full_pop");
    rd_chk("full_resume", A_STAT, 32'h208);
    while (exp_q.size() > 0) pop_chk("drain");

    // COEF0 write stalls behind a running pixel
    p = 32'h00806040;
    wr(A_PIX, p);
    t0 = ack_cyc;
    exp_q.push_back(ref_csc(p, 0));
    idle(2);
    wr(A_COEF, 32'd2000);
    chk("coef_stall", 32'(ack_cyc - t0), 32'd12);
    coef_m[0] = 2000;
    idle(3);
    pop_chk("old_coef");
    p = 32'h00C0A020;
    wr(A_PIX, p);
    exp_q.push_back(ref_csc(p, 0));
    idle(12);
    pop_chk("new_coef");

    // flush: queued result and in-flight pixel both discarded
    wr(A_PIX, 32'h00112233);
    idle(12);
    wr(A_PIX, 32'h00445566);
    idle(3);
    wr(A_CTRL, 32'h2);
    rd_chk("flush_stat", A_STAT, 32'h100);
    idle(15);
    rd_chk("flush_late", A_STAT, 32'h100);
    rd_chk("flush_coef", A_COEF, 32'd2000);

    // randomized traffic with random coefficients and bypass toggling
    for (int i = 0; i < 9; i++) begin
      coef_m[i] = int'($urandom_range(0, 65535)) - 32768;
      wr(A_COEF + 32'(4*i), 32'(coef_m[i]));
    end
    byp = 0;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 5))
        0: begin
          byp = $urandom_range(0, 1) == 1;
          wr(A_CTRL, {31'b0, byp});
        end
        1, 2, 3: if (exp_q.size() < 8) begin
          p = {8'h0, 24'($urandom)};
          wr(A_PIX, p);
          exp_q.push_back(ref_csc(p, byp));
          idle(12);
        end
        default: pop_chk("rand_pop");
      endcase
    end
    rd_chk("rand_stat", A_STAT, stat_m(0));
    wr(A_CTRL, 32'h6);
    exp_q.delete();
    under_m = 0;

    // reset in the middle of MAC
    wr(A_PIX, 32'h00FFFFFF);
    idle(3);
    rst_n = 0;
    #2;
    chk("mid_rst_ack", {31'b0, bus.ACK_O}, 32'd0);
    idle(2);
    rst_n = 1;
    idle(15);
    rd_chk("mid_rst_stat", A_STAT, 32'h100);
    rd_chk("mid_rst_coef", A_COEF, 32'd4899);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=%0d exp=done", cyc);
    $fatal(1);
  end
endmodule
